// File: rtl/spdif_sample_buffer_pkg.sv
// Shared types for the S/PDIF sample buffer: sample width, channel tag, tagged entry, buffer state.
package spdif_pkg;

  localparam int SAMPLE_W = 20;

  typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} spdif_ch_t;

  typedef struct packed {
    spdif_ch_t             ch;
    logic [SAMPLE_W-1:0]   data;
  } tagged_sample_t;

  typedef enum logic {BUF_FILL = 1'b0, BUF_STREAM = 1'b1} buf_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spdif_sample_buffer_sample_ram.sv
// Simple dual-port sample store, one write and one registered read port; read data valid 1 clk after rd_en.
// No flow control here: the caller guarantees address validity, and a same-address read returns the old entry.
module sample_ram #(
  parameter int  DEPTH = 64,
  parameter int  W     = 21,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/spdif_sample_buffer.sv
// Elastic L/R-aligned sample buffer between the S/PDIF decoder and retransmitter; prefills before streaming.
// One-clock pull latency; writes are dropped (and counted) when full, empty pulls return mute (and are counted).
module spdif_sample_buffer
  import spdif_pkg::*;
#(
  parameter int  DEPTH   = 64,
  parameter int  PREFILL = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vin,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                in_channel,
  input  logic                flush,
  input  logic                frame_ready,
  output logic [SAMPLE_W-1:0] dout,
  output logic                dout_channel,
  output logic                dout_valid,
  output logic                fifo_ready,
  output logic [CW-1:0]       count,
  output logic [7:0]          overflow_count,
  output logic [7:0]          underflow_count
);

  logic [AW:0]    wr_ptr, rd_ptr;
  buf_state_t     state;
  logic           expect_ch;
  logic           mute;
  tagged_sample_t wr_entry, rd_entry;

  logic empty, full, cand_vld, pull_vld, pop, push, underflow, drop;

  // The extra MSB tells a full buffer (MSBs differ) from an empty one (pointers equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cand_vld  = vin && (in_channel == expect_ch);
  assign pull_vld  = frame_ready && (state == BUF_STREAM);
  assign pop       = pull_vld && !empty && !flush && !rst;
  assign push      = cand_vld && (!full || pop) && !flush && !rst;
  assign underflow = pull_vld && empty && !flush;
  assign drop      = cand_vld && full && !pop && !flush;

  assign wr_entry  = '{ch: spdif_ch_t'(in_channel), data: din};

  sample_ram #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (wr_entry),
    .rd_en   (pop),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (rd_entry)
  );

  // The RAM read register is the output register; mute masks it after reset or an empty pull.
  assign dout         = mute ? '0   : rd_entry.data;
  assign dout_channel = mute ? 1'b0 : rd_entry.ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      state           <= BUF_FILL;
      fifo_ready      <= 1'b0;
      expect_ch       <= 1'b0;
      mute            <= 1'b1;
      dout_valid      <= 1'b0;
      overflow_count  <= '0;
      underflow_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= BUF_FILL;
      fifo_ready <= 1'b0;
      expect_ch  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;

      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        expect_ch <= ~expect_ch;
      end else if (vin && !cand_vld) begin
        expect_ch <= 1'b0;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        mute       <= 1'b0;
        dout_valid <= 1'b1;
      end

      if (drop) overflow_count <= sat_inc8(overflow_count);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        BUF_FILL: begin
          // Only start streaming on a whole number of L/R pairs.
          if (count >= CW'(PREFILL) && !count[0]) begin
            state      <= BUF_STREAM;
            fifo_ready <= 1'b1;
          end
        end
        BUF_STREAM: begin
          if (underflow) begin
            mute            <= 1'b1;
            dout_valid      <= 1'b1;
            underflow_count <= sat_inc8(underflow_count);
            state           <= BUF_FILL;
            fifo_ready      <= 1'b0;
          end
        end
        default: state <= BUF_FILL;
      endcase
    end
  end

endmodule
